// File: rtl/muldiv_sequencer_if.sv
// Handshake/data bundle between the execute stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             write_hi;
    logic             write_lo;
    logic [WIDTH-1:0] write_data;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall_pipeline;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, write_hi, write_lo, write_data, flush,
        input  hi, lo, busy, stall_pipeline, done, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, write_hi, write_lo, write_data, flush,
        output hi, lo, busy, stall_pipeline, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning HI/LO. Shift-add multiply and restoring
// divide on operand magnitudes, one iteration per clock, sign fixup in a final cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    muldiv_sequencer_if.slave    bus
);
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_COUNT = CW'(ITERS - 1);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement negate of a word when neg is set.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = (~v) + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negate of a double word when neg is set.
    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        logic [2*WIDTH-1:0] r;
        if (neg) begin
            r = (~v) + ONE_2W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] acc_hi_r;     // partial product high / running remainder
    logic [WIDTH-1:0] acc_lo_r;     // multiplier being shifted out / dividend-quotient
    logic [WIDTH-1:0] opnd_r;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] dividend_r;   // raw dividend, returned in HI on divide by zero
    logic             is_div_r;
    logic             neg_a_r;
    logic             neg_b_r;
    logic             b_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;
    logic             dbz_r;

    logic             idle_or_done_s;
    logic             accept_s;
    logic             op_signed_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [WIDTH-1:0] fix_lo_s;

    assign idle_or_done_s = (state_r == S_IDLE) || (state_r == S_DONE);
    assign accept_s       = bus.start && !bus.flush && idle_or_done_s;
    assign op_signed_s    = !bus.op[0];
    assign neg_a_s        = op_signed_s && bus.operand_a[WIDTH-1];
    assign neg_b_s        = op_signed_s && bus.operand_b[WIDTH-1];
    assign mag_a_s        = cond_neg_w(bus.operand_a, neg_a_s);
    assign mag_b_s        = cond_neg_w(bus.operand_b, neg_b_s);

    // One shift-add or restoring-divide iteration on the accumulator pair.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO_W});
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, opnd_r};
        step_hi_s   = acc_hi_r;
        step_lo_s   = acc_lo_r;
        if (is_div_r) begin
            if (!div_trial_s[WIDTH]) begin
                step_hi_s = div_trial_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                // Remainder stays below the divisor, so the dropped top bit is zero.
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the magnitude result, and the divide-by-zero substitute.
    always_comb begin
        prod_fix_s = cond_neg_2w({acc_hi_r, acc_lo_r}, neg_a_r ^ neg_b_r);
        fix_hi_s   = prod_fix_s[2*WIDTH-1:WIDTH];
        fix_lo_s   = prod_fix_s[WIDTH-1:0];
        if (is_div_r) begin
            if (b_zero_r) begin
                fix_hi_s = dividend_r;
                fix_lo_s = ONES_W;
            end else begin
                // Remainder follows the dividend; quotient truncates toward zero.
                fix_hi_s = cond_neg_w(acc_hi_r, neg_a_r);
                fix_lo_s = cond_neg_w(acc_lo_r, neg_a_r ^ neg_b_r);
            end
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Sequencer FSM with operand latch, iteration datapath and registered HI/LO/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            count_r    <= {CW{1'b0}};
            acc_hi_r   <= ZERO_W;
            acc_lo_r   <= ZERO_W;
            opnd_r     <= ZERO_W;
            dividend_r <= ZERO_W;
            is_div_r   <= 1'b0;
            neg_a_r    <= 1'b0;
            neg_b_r    <= 1'b0;
            b_zero_r   <= 1'b0;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done_r  <= 1'b0;
                    dbz_r   <= 1'b0;
                    count_r <= {CW{1'b0}};
                    // MTHI/MTLO commit even when an op starts at the same edge.
                    if (bus.write_hi) begin
                        hi_r <= bus.write_data;
                    end
                    if (bus.write_lo) begin
                        lo_r <= bus.write_data;
                    end
                    if (accept_s) begin
                        state_r    <= S_CALC;
                        is_div_r   <= bus.op[1];
                        neg_a_r    <= neg_a_s;
                        neg_b_r    <= neg_b_s;
                        b_zero_r   <= (bus.operand_b == ZERO_W);
                        dividend_r <= bus.operand_a;
                        acc_hi_r   <= ZERO_W;
                        if (bus.op[1]) begin
                            opnd_r   <= mag_b_s;
                            acc_lo_r <= mag_a_s;
                        end else begin
                            opnd_r   <= mag_a_s;
                            acc_lo_r <= mag_b_s;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        state_r <= S_IDLE;
                        count_r <= {CW{1'b0}};
                    end else begin
                        acc_hi_r <= step_hi_s;
                        acc_lo_r <= step_lo_s;
                        if (count_r == LAST_COUNT) begin
                            state_r <= S_FIX;
                            count_r <= {CW{1'b0}};
                        end else begin
                            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_FIX: begin
                    if (bus.flush) begin
                        state_r <= S_IDLE;
                    end else begin
                        hi_r    <= fix_hi_s;
                        lo_r    <= fix_lo_s;
                        done_r  <= 1'b1;
                        dbz_r   <= is_div_r && b_zero_r;
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.hi             = hi_r;
    assign bus.lo             = lo_r;
    assign bus.done           = done_r;
    assign bus.div_by_zero    = dbz_r;
    assign bus.busy           = (state_r == S_CALC) || (state_r == S_FIX);
    assign bus.stall_pipeline = bus.busy || (bus.start && idle_or_done_s);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected HI/LO/flag,
// an independent monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(32)) bus();
    muldiv_sequencer #(.WIDTH(32), .ITERS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic [64:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        logic [64:0] e;
        if (reset === 1'b1 && bus.done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("hi", {32'd0, bus.hi}, {32'd0, e[64:33]});
                chk("lo", {32'd0, bus.lo}, {32'd0, e[32:1]});
                chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e[0]});
            end
        end
    end

    task automatic write_reg(input bit to_hi, input logic [31:0] d);
        @(negedge clk);
        bus.write_hi = to_hi;
        bus.write_lo = !to_hi;
        bus.write_data = d;
        @(posedge clk);
        #1;
        bus.write_hi = 1'b0;
        bus.write_lo = 1'b0;
        if (to_hi) chk("mthi_idle", {32'd0, bus.hi}, {32'd0, d});
        else       chk("mtlo_idle", {32'd0, bus.lo}, {32'd0, d});
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input bit now, input int ign_at, input int wr_at,
                         input int flush_at, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
        bit seen;
        seen = 1'b0;
        if (expect_done) sb.push_back({eh, el, ed});
        if (!now) @(negedge clk);
        bus.start = 1'b1;
        bus.op = o;
        bus.operand_a = a;
        bus.operand_b = b;
        #1;
        chk("stall_on_start", {63'd0, bus.stall_pipeline}, 64'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.operand_a = ~a;          // operands must already be latched
        bus.operand_b = ~b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == ign_at) begin
                bus.start = 1'b1;
                bus.op = 2'b11;
                bus.operand_a = 32'd1;
                bus.operand_b = 32'd1;
            end
            if (ign_at >= 0 && i == ign_at + 1) bus.start = 1'b0;
            if (i == wr_at) begin
                bus.write_hi = 1'b1;
                bus.write_data = 32'hDEADBEEF;
            end
            if (wr_at >= 0 && i == wr_at + 1) begin
                bus.write_hi = 1'b0;
                chk("mthi_busy_ignored", {32'd0, bus.hi}, {32'd0, hold_hi});
            end
            if (i == flush_at) bus.flush = 1'b1;
            if (flush_at >= 0 && i == flush_at + 1) begin
                bus.flush = 1'b0;
                chk("busy_after_flush", {63'd0, bus.busy}, 64'd0);
            end
            if (expect_done && i == 0) chk("busy_calc", {63'd0, bus.busy}, 64'd1);
            if (expect_done && i == 32) chk("stall_fix", {62'd0, bus.busy, bus.stall_pipeline}, 64'd3);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                chk("latency", i, 33);
                chk("busy_at_done", {63'd0, bus.busy}, 64'd0);
                break;
            end
        end
        if (expect_done) begin
            chk("done_timeout", {63'd0, seen}, 64'd1);
        end else begin
            chk("flush_no_done", {63'd0, seen}, 64'd0);
            chk("flush_hi_kept", {32'd0, bus.hi}, {32'd0, hold_hi});
            chk("flush_lo_kept", {32'd0, bus.lo}, {32'd0, hold_lo});
        end
    endtask

    initial begin
        int d0;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = 32'd0; bus.operand_b = 32'd0;
        bus.write_hi = 1'b0; bus.write_lo = 1'b0; bus.write_data = 32'd0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {bus.hi, bus.lo}, 64'd0);
        chk("reset_flags", {60'd0, bus.busy, bus.stall_pipeline, bus.done, bus.div_by_zero}, 64'd0);
        reset = 1'b1;

        // Reset in the middle of CALC discards the op and clears HI/LO.
        write_reg(1'b1, 32'h00000055);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd5; bus.operand_b = 32'd6;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("midreset_flags", {61'd0, bus.busy, bus.stall_pipeline, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        d0 = done_seen;
        repeat (40) @(negedge clk);
        chk("midreset_no_done", done_seen, d0);

        // Multiply.
        do_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0, -1, -1, -1, 32'd0, 32'd0);
        do_op(2'b01, 32'hFFFFFFFE, 32'h00000003, 1'b1, 32'h00000002, 32'hFFFFFFFA, 1'b0, 1'b0, -1, -1, -1, 32'd0, 32'd0);
        // Divide.
        do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, -1, -1, -1, 32'd0, 32'd0);
        do_op(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 1'b0, -1, -1, -1, 32'd0, 32'd0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 1'b0, 1'b0, -1, -1, -1, 32'd0, 32'd0);
        // Divide by zero; the flag lasts only the done cycle.
        do_op(2'b11, 32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0, -1, -1, -1, 32'd0, 32'd0);
        @(negedge clk);
        chk("dbz_clears", {62'd0, bus.done, bus.div_by_zero}, 64'd0);

        // Start in CALC ignored, MTHI while busy ignored, then back-to-back start from DONE.
        do_op(2'b01, 32'd7, 32'd8, 1'b1, 32'd0, 32'd56, 1'b0, 1'b0, 5, 10, -1, 32'h12345678, 32'd0);
        do_op(2'b00, 32'hFFFFFFFD, 32'd4, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, 1'b1, -1, -1, -1, 32'd0, 32'd0);
        write_reg(1'b1, 32'hDEADBEEF);

        // Flush mid-CALC keeps HI/LO and never pulses done.
        write_reg(1'b1, 32'h00000001);
        write_reg(1'b0, 32'h00000002);
        do_op(2'b01, 32'd5, 32'd6, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, -1, -1, 20, 32'h00000001, 32'h00000002);

        // Flush together with start in IDLE suppresses the start.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd5; bus.operand_b = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start_busy", {63'd0, bus.busy}, 64'd0);
        d0 = done_seen;
        repeat (40) @(negedge clk);
        chk("flush_start_no_done", done_seen, d0);
        chk("flush_start_hilo", {bus.hi, bus.lo}, {32'h00000001, 32'h00000002});

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller beside the execute-stage ALU; owns the HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- Runs a 32-iteration shift-add multiply or restoring divide.
- Stalls the IF/ID/ID-EX pipeline registers while busy.
- Result is held in HI/LO for later MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand and HI/LO width
- ITERS, 32, iterations per operation; must equal WIDTH

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  issue a mul/div op, valid for one cycle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  32  rs value (multiplicand/dividend)
- operand_b  input  32  rt value (multiplier/divisor)
- write_hi  input  1  MTHI
- write_lo  input  1  MTLO
- write_data  input  32  MTHI/MTLO data
- flush  input  1  abort the in-flight op (branch squash)
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  an op is in flight
- stall_pipeline  output  1  freeze the upstream pipeline registers
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  divisor was 0; valid while done=1

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; hi=0, lo=0, busy=0, stall_pipeline=0, done=0, div_by_zero=0, counter=0. Reset mid-operation discards the op.
- States and transitions:
  - IDLE: go to CALC when start is sampled.
  - CALC: runs exactly ITERS edges, counter 0..31, then goes to FIX.
  - FIX: one edge, then goes to DONE.
  - DONE: one edge, then goes to IDLE, unless start is sampled, in which case it goes to CALC.
- start is accepted only in IDLE or DONE. In CALC or FIX it is ignored; no queuing.
- Latency: start accepted at edge E0. Iterations run at E1..E32. The sign fixup happens at E33, and hi/lo are written at E33. done=1 in the cycle after E33. Next start is accepted at E34 at the earliest.
- busy = state is CALC or FIX.
- stall_pipeline is combinational: busy OR (start AND state is IDLE/DONE).
- Operands are latched at E0 into internal registers; later changes on operand_a/operand_b have no effect.
- Signed ops: magnitudes are iterated; sign is corrected in FIX.
- Multiply: {hi,lo} = 64-bit product. MULT is two's-complement, MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no flag).
- Divide by zero: full 33-edge latency is kept; hi=operand_a, lo=0xFFFFFFFF, div_by_zero=1 during done. div_by_zero clears on the next edge.
- MTHI/MTLO:
  - Take effect at the edge only in IDLE or DONE.
  - Ignored while busy.
  - If write_hi/lo and start are sampled at the same edge, the write commits first and the op still starts; the op result overwrites at E33.
- flush:
  - In CALC or FIX: go to IDLE at the next edge; hi/lo unchanged; no done pulse.
  - In IDLE/DONE: start at the same edge is suppressed.
  - flush has priority over start and over the FIX write.
- hi/lo change only on: the FIX edge, MTHI/MTLO writes, or reset.

Test Plan:
1. Reset low mid-CALC (after E10), release → hi=0, lo=0, busy=0, done never pulses, state IDLE.
2. MULT a=0xFFFFFFFE (-2), b=0x00000003 → after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle, stall_pipeline high from start cycle through FIX cycle. MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
3. DIV a=0xFFFFFFF9 (-7), b=0x00000002 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU a=0x12345678, b=0 → hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1 with done.
5. start during CALC ignored. start in DONE cycle accepted → second result 33 edges later. MTHI 0xDEADBEEF while busy ignored; MTHI in IDLE → hi=0xDEADBEEF next edge.
6. flush at E20 of MULTU 5×6 with hi/lo=0x1/0x2 → hi=0x1, lo=0x2 retained, no done, busy=0 next cycle. flush with start in IDLE → no op starts.
